// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 16-bit core: opcodes, the bubble instruction,
// the fetch FSM state type and the IF/ID update select.
package isa_pkg;

  typedef logic [15:0] word_t;

  localparam logic [4:0] HALT_OP  = 5'b00000;
  localparam logic [4:0] NOP_OP   = 5'b00001;
  localparam word_t      NOP_INST = {NOP_OP, 11'b0};

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_DRAIN,
    S_HALTED
  } fetch_state_t;

  typedef enum logic [1:0] {
    IFID_BUBBLE,
    IFID_HOLD,
    IFID_LOAD
  } ifid_sel_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register {inst, pc_nx, valid}. It can load a new instruction,
// hold its contents, or collapse to a bubble.
module if_id_reg
  import isa_pkg::*;
#(
  parameter word_t BUBBLE_INST = 16'h0800
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  ifid_sel_t sel_i,
  input  word_t     inst_i,
  input  word_t     pc_nx_i,
  output word_t     inst_o,
  output word_t     pc_nx_o,
  output logic      valid_o
);

  word_t inst_q, inst_d;
  word_t pc_nx_q, pc_nx_d;
  logic  valid_q, valid_d;

  always_comb begin
    inst_d  = BUBBLE_INST;
    pc_nx_d = '0;
    valid_d = 1'b0;
    case (sel_i)
      IFID_HOLD: begin
        inst_d  = inst_q;
        pc_nx_d = pc_nx_q;
        valid_d = valid_q;
      end
      IFID_LOAD: begin
        inst_d  = inst_i;
        pc_nx_d = pc_nx_i;
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inst_q  <= BUBBLE_INST;
      pc_nx_q <= '0;
      valid_q <= 1'b0;
    end else begin
      inst_q  <= inst_d;
      pc_nx_q <= pc_nx_d;
      valid_q <= valid_d;
    end
  end

  assign inst_o  = inst_q;
  assign pc_nx_o = pc_nx_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch controller: single-outstanding request FSM toward the
// instruction memory, one-entry skid buffer for decode stalls, and IF/ID register.
module fetch_stage
  import isa_pkg::*;
#(
  parameter word_t      NOP_INST = isa_pkg::NOP_INST,
  parameter logic [4:0] HALT_OP  = isa_pkg::HALT_OP
) (
  input  logic  clk,
  input  logic  rst,
  input  word_t pc_addr,
  input  word_t pc_nx,
  input  logic  stall,
  input  logic  flush,
  output logic  imem_req,
  output word_t imem_addr,
  input  word_t imem_rdata,
  input  logic  imem_valid,
  output logic  pc_en,
  output word_t if_id_inst,
  output word_t if_id_pc_nx,
  output logic  if_id_valid,
  output logic  halted
);

  fetch_state_t state_q, state_d;
  word_t        skid_q, skid_d;
  word_t        pc_nx_q, pc_nx_d;
  word_t        acc_inst;
  logic         accept;
  logic         req;
  ifid_sel_t    sel;

  always_comb begin
    state_d  = state_q;
    skid_d   = skid_q;
    pc_nx_d  = pc_nx_q;
    acc_inst = skid_q;
    accept   = 1'b0;
    req      = 1'b0;
    case (state_q)
      S_FETCH: begin
        req = ~flush;
        if (!flush) begin
          state_d = S_WAIT;
          pc_nx_d = pc_nx;
        end
      end
      S_WAIT: begin
        // A redirect wins over returning data; without data the reply is still owed.
        if (flush) begin
          state_d = imem_valid ? S_FETCH : S_DRAIN;
        end else if (imem_valid) begin
          if (stall) begin
            state_d = S_HOLD;
            skid_d  = imem_rdata;
          end else begin
            accept   = 1'b1;
            acc_inst = imem_rdata;
          end
        end
      end
      S_HOLD: begin
        if (flush) begin
          state_d = S_FETCH;
          skid_d  = NOP_INST;
        end else if (!stall) begin
          accept = 1'b1;
        end
      end
      S_DRAIN: begin
        if (imem_valid) state_d = S_FETCH;
      end
      S_HALTED: begin
        if (flush) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    if (accept) state_d = (acc_inst[15:11] == HALT_OP) ? S_HALTED : S_FETCH;
  end

  always_comb begin
    sel = IFID_BUBBLE;
    if (flush)       sel = IFID_BUBBLE;
    else if (stall)  sel = IFID_HOLD;
    else if (accept) sel = IFID_LOAD;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      skid_q  <= NOP_INST;
      pc_nx_q <= '0;
    end else begin
      state_q <= state_d;
      skid_q  <= skid_d;
      pc_nx_q <= pc_nx_d;
    end
  end

  // Strobes are gated by rst so they read 0 while reset is held.
  assign imem_req  = req & rst;
  assign imem_addr = imem_req ? pc_addr : '0;
  assign pc_en     = (accept | flush) & rst;
  assign halted    = (state_q == S_HALTED);

  if_id_reg #(
    .BUBBLE_INST(NOP_INST)
  ) u_if_id (
    .clk_i   (clk),
    .rst_ni  (rst),
    .sel_i   (sel),
    .inst_i  (acc_inst),
    .pc_nx_i (pc_nx_q),
    .inst_o  (if_id_inst),
    .pc_nx_o (if_id_pc_nx),
    .valid_o (if_id_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: PC block and variable-latency memory modelled here,
// directed vector table, hand-written corner sequences and a random stream check.
module tb_fetch_stage;
  import isa_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] pc_addr, pc_nx, imem_addr, imem_rdata, if_id_inst, if_id_pc_nx;
  logic        stall, flush, imem_req, imem_valid, pc_en, if_id_valid, halted;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .pc_addr    (pc_addr),
    .pc_nx      (pc_nx),
    .stall      (stall),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .pc_en      (pc_en),
    .if_id_inst (if_id_inst),
    .if_id_pc_nx(if_id_pc_nx),
    .if_id_valid(if_id_valid),
    .halted     (halted)
  );

  int          total = 0;
  int          bad = 0;
  logic [15:0] mem [0:255];
  logic        pend;
  int          cnt;
  int          lat;
  logic [15:0] paddr;
  logic [15:0] pc;
  logic [15:0] target;

  assign pc_addr = pc;
  assign pc_nx   = pc + 16'd2;

  typedef struct {
    logic        stall;
    logic        flush;
    logic        req;
    logic [15:0] addr;
    logic        pc_en;
    logic [15:0] inst;
    logic [15:0] pcnx;
    logic        valid;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] idx(input logic [15:0] a);
    return a[8:1];
  endfunction

  task automatic init_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h4123 + 16'(i);
  endtask

  // Drive one cycle's inputs at the falling edge, then let combinational outputs settle.
  task automatic cyc_drive(input logic s, input logic f);
    @(negedge clk);
    stall      = s;
    flush      = f;
    imem_valid = 1'b0;
    imem_rdata = 16'hDEAD;
    if (pend) begin
      if (cnt == 0) begin
        imem_valid = 1'b1;
        imem_rdata = mem[idx(paddr)];
        pend       = 1'b0;
      end else begin
        cnt--;
      end
    end
    #1;
  endtask

  // Record a new request, cross the rising edge, and update the PC block.
  task automatic cyc_finish();
    logic en;
    logic fl;
    en = pc_en;
    fl = flush;
    if (imem_req) begin
      chk("one_outstanding", {15'b0, pend}, 16'h0);
      pend  = 1'b1;
      cnt   = lat - 1;
      paddr = imem_addr;
    end
    @(posedge clk);
    #1;
    if (en) pc = fl ? target : pc + 16'd2;
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    stall      = 1'b0;
    flush      = 1'b0;
    imem_valid = 1'b0;
    imem_rdata = 16'h0;
    pend       = 1'b0;
    cnt        = 0;
    paddr      = 16'h0;
    pc         = 16'h0;
    target     = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {15'b0, imem_req}, 16'h0);
    chk("rst_pc_en", {15'b0, pc_en}, 16'h0);
    chk("rst_inst", if_id_inst, 16'h0800);
    chk("rst_pcnx", if_id_pc_nx, 16'h0);
    chk("rst_valid", {15'b0, if_id_valid}, 16'h0);
    chk("rst_halted", {15'b0, halted}, 16'h0);
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] h_inst, h_pcnx;
    logic        h_valid, s, en;
    int          acc;

    tbl[0] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0800, 16'h0000, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h4123, 16'h0002, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, 16'h0800, 16'h0000, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h4124, 16'h0004, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 16'h0004, 1'b0, 16'h4124, 16'h0004, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h4124, 16'h0004, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h4124, 16'h0004, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hA001, 16'h0006, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 16'h0006, 1'b0, 16'h0800, 16'h0000, 1'b0};

    // Directed: L=1 back-to-back fetches, then a 3-cycle stall across a return.
    init_mem();
    mem[2] = 16'hA001;
    lat = 1;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cyc_drive(tbl[i].stall, tbl[i].flush);
      chk($sformatf("tbl%0d_req", i), {15'b0, imem_req}, {15'b0, tbl[i].req});
      chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_pc_en", i), {15'b0, pc_en}, {15'b0, tbl[i].pc_en});
      cyc_finish();
      chk($sformatf("tbl%0d_inst", i), if_id_inst, tbl[i].inst);
      chk($sformatf("tbl%0d_pcnx", i), if_id_pc_nx, tbl[i].pcnx);
      chk($sformatf("tbl%0d_valid", i), {15'b0, if_id_valid}, {15'b0, tbl[i].valid});
    end

    // L=3 with flush in the second WAIT cycle, then drain.
    init_mem();
    mem[idx(16'h0082)] = 16'h0000;
    lat = 3;
    do_reset();
    cyc_drive(1'b0, 1'b0);
    chk("fl_req0", {15'b0, imem_req}, 16'h1);
    cyc_finish();
    cyc_drive(1'b0, 1'b0);
    chk("fl_wait1_pc_en", {15'b0, pc_en}, 16'h0);
    cyc_finish();
    target = 16'h0040;
    cyc_drive(1'b0, 1'b1);
    chk("fl_pc_en", {15'b0, pc_en}, 16'h1);
    chk("fl_req", {15'b0, imem_req}, 16'h0);
    cyc_finish();
    chk("fl_bubble_inst", if_id_inst, 16'h0800);
    chk("fl_bubble_valid", {15'b0, if_id_valid}, 16'h0);
    chk("fl_bubble_pcnx", if_id_pc_nx, 16'h0);
    cyc_drive(1'b0, 1'b0);
    chk("drain_valid_seen", {15'b0, imem_valid}, 16'h1);
    chk("drain_pc_en", {15'b0, pc_en}, 16'h0);
    chk("drain_req", {15'b0, imem_req}, 16'h0);
    cyc_finish();
    chk("drain_ifid_valid", {15'b0, if_id_valid}, 16'h0);
    lat = 1;
    cyc_drive(1'b0, 1'b0);
    chk("redir_req", {15'b0, imem_req}, 16'h1);
    chk("redir_addr", imem_addr, 16'h0040);
    cyc_finish();
    cyc_drive(1'b0, 1'b0);
    chk("redir_pc_en", {15'b0, pc_en}, 16'h1);
    cyc_finish();
    chk("redir_inst", if_id_inst, mem[idx(16'h0040)]);
    chk("redir_pcnx", if_id_pc_nx, 16'h0042);

    // flush + stall together with returning data.
    cyc_drive(1'b0, 1'b0);
    chk("fs_req_addr", imem_addr, 16'h0042);
    cyc_finish();
    target = 16'h0080;
    cyc_drive(1'b1, 1'b1);
    chk("fs_pc_en", {15'b0, pc_en}, 16'h1);
    cyc_finish();
    chk("fs_inst", if_id_inst, 16'h0800);
    chk("fs_valid", {15'b0, if_id_valid}, 16'h0);
    cyc_drive(1'b0, 1'b0);
    chk("fs_fetch_req", {15'b0, imem_req}, 16'h1);
    chk("fs_fetch_addr", imem_addr, 16'h0080);
    cyc_finish();
    cyc_drive(1'b0, 1'b0);
    cyc_finish();
    chk("fs_next_inst", if_id_inst, mem[idx(16'h0080)]);

    // HALT at 0x82.
    cyc_drive(1'b0, 1'b0);
    chk("halt_req_addr", imem_addr, 16'h0082);
    cyc_finish();
    cyc_drive(1'b0, 1'b0);
    chk("halt_pc_en", {15'b0, pc_en}, 16'h1);
    cyc_finish();
    chk("halt_inst", if_id_inst, 16'h0000);
    chk("halt_ifid_valid", {15'b0, if_id_valid}, 16'h1);
    chk("halt_pcnx", if_id_pc_nx, 16'h0084);
    chk("halted_set", {15'b0, halted}, 16'h1);
    for (int i = 0; i < 10; i++) begin
      cyc_drive(1'b0, 1'b0);
      chk($sformatf("halted_noreq%0d", i), {15'b0, imem_req}, 16'h0);
      chk($sformatf("halted_nopcen%0d", i), {15'b0, pc_en}, 16'h0);
      cyc_finish();
      chk($sformatf("halted_hold%0d", i), {15'b0, halted}, 16'h1);
    end
    target = 16'h0010;
    cyc_drive(1'b0, 1'b1);
    chk("unhalt_pc_en", {15'b0, pc_en}, 16'h1);
    cyc_finish();
    chk("unhalt_halted", {15'b0, halted}, 16'h0);

    // Fetch one instruction, then stall into HOLD and reset asynchronously.
    cyc_drive(1'b0, 1'b0);
    chk("restart_addr", imem_addr, 16'h0010);
    cyc_finish();
    cyc_drive(1'b0, 1'b0);
    cyc_finish();
    chk("restart_inst", if_id_inst, mem[idx(16'h0010)]);
    cyc_drive(1'b1, 1'b0);
    cyc_finish();
    cyc_drive(1'b1, 1'b0);
    chk("hold_enter_pc_en", {15'b0, pc_en}, 16'h0);
    cyc_finish();
    cyc_drive(1'b1, 1'b0);
    chk("hold_pc_en", {15'b0, pc_en}, 16'h0);
    chk("hold_inst_kept", if_id_inst, mem[idx(16'h0010)]);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_req", {15'b0, imem_req}, 16'h0);
    chk("arst_pc_en", {15'b0, pc_en}, 16'h0);
    chk("arst_inst", if_id_inst, 16'h0800);
    chk("arst_pcnx", if_id_pc_nx, 16'h0);
    chk("arst_valid", {15'b0, if_id_valid}, 16'h0);
    chk("arst_halted", {15'b0, halted}, 16'h0);

    // Random stalls and latencies: accepted stream must be the sequential program.
    init_mem();
    lat = 1;
    do_reset();
    acc = 0;
    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(0, 9) < 3);
      cyc_drive(s, 1'b0);
      if (imem_req) chk("rnd_addr", imem_addr, 16'(2 * acc));
      chk("rnd_pcen_under_stall", {15'b0, pc_en & s}, 16'h0);
      h_inst  = if_id_inst;
      h_pcnx  = if_id_pc_nx;
      h_valid = if_id_valid;
      en      = pc_en;
      lat     = $urandom_range(1, 4);
      cyc_finish();
      if (en) begin
        chk("rnd_inst", if_id_inst, mem[idx(16'(2 * acc))]);
        chk("rnd_pcnx", if_id_pc_nx, 16'(2 * acc + 2));
        chk("rnd_valid", {15'b0, if_id_valid}, 16'h1);
        acc++;
      end else if (s) begin
        chk("rnd_hold_inst", if_id_inst, h_inst);
        chk("rnd_hold_pcnx", if_id_pc_nx, h_pcnx);
        chk("rnd_hold_valid", {15'b0, if_id_valid}, {15'b0, h_valid});
      end else begin
        chk("rnd_bubble_valid", {15'b0, if_id_valid}, 16'h0);
      end
    end
    chk("rnd_progress", {15'b0, acc > 20}, 16'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch controller and IF/ID pipeline register for the 16-bit core. Sits between the PC block (which supplies the current address and PC+2) and the decode stage. Issues one request at a time to a variable-latency instruction memory. Drives the PC block's write enable, and handles decode stalls, branch/jump flushes and HALT.

## Interface
Parameters:
- NOP_INST, 16'h0800, bubble instruction loaded on reset/flush/empty cycles (opcode 5'b00001)
- HALT_OP, 5'b00000, opcode that stops fetching

Ports:
- One clock; reset is asynchronous and active-low.
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- pc_addr  in  16  current PC (PC register output)
- pc_nx  in  16  PC+2 from PC block
- stall  in  1  decode cannot accept; IF/ID holds
- flush  in  1  redirect (taken branch/jump) this cycle; PC block loads target when pc_en=1
- imem_req  out  1  request strobe, one cycle per request
- imem_addr  out  16  request address (= pc_addr while imem_req=1, else 0)
- imem_rdata  in  16  returned instruction
- imem_valid  in  1  imem_rdata valid; exactly one per request, ≥1 cycle after imem_req
- pc_en  out  1  write enable to PC register
- if_id_inst  out  16  instruction to decode
- if_id_pc_nx  out  16  PC+2 of that instruction
- if_id_valid  out  1  if_id_inst is a real instruction
- halted  out  1  HALT reached, fetching stopped

## Operation
- States: FETCH, WAIT, HOLD, DRAIN, HALTED.
- FETCH: imem_req = ~flush. If flush, stay in FETCH. Otherwise go to WAIT and latch pc_nx into pc_nx_q.
- WAIT: on imem_valid:
  - flush → FETCH, data dropped.
  - stall → HOLD, data captured in skid buffer.
  - else accept.
  - If flush without imem_valid → DRAIN.
- HOLD: on ~stall, accept from the skid buffer. On flush, discard the buffer → FETCH.
- DRAIN: wait for imem_valid, discard the data → FETCH. flush here keeps DRAIN.
- Accept:
  - IF/ID loads {inst, pc_nx_q, valid=1} and pc_en=1.
  - Next state is HALTED if inst[15:11]==HALT_OP, else FETCH.
- HALTED: no requests, halted=1, pc_en=0. flush → FETCH and halted=0.
- pc_en = accept | flush. Combinational, asserted in the same cycle.
- IF/ID update priority:
  1. flush → bubble (NOP_INST, valid=0, pc_nx 0)
  2. stall → hold
  3. accept → load
  4. otherwise → bubble
- flush beats stall in every state. flush together with imem_valid in WAIT drops the data.
- At most one outstanding request. imem_valid in FETCH/HOLD/HALTED is a protocol error and is ignored.

## Timing
- Reset values, asynchronous on rst=0: state FETCH, if_id_inst=NOP_INST, if_id_pc_nx=0, if_id_valid=0, halted=0, imem_req=0, pc_en=0, skid buffer=NOP_INST.
- First imem_req in the first cycle after rst deasserts.
- Memory latency L cycles gives IF/ID update at the edge ending the imem_valid cycle. Minimum is 2 cycles per instruction (FETCH + WAIT with L=1).
- pc_en pulses for exactly one cycle per accepted instruction. It never pulses in HOLD while stall=1.
- Reset mid-request: the outstanding response is not tracked. The memory is reset by the same rst.
- PC wrap: addresses come from the PC block; 16'hFFFE→16'h0000 needs no special handling.

## Structure
- Shared package `isa_pkg`: opcode constants (HALT_OP, NOP opcode, NOP_INST), the fetch state enum `fetch_state_t`, and the 16-bit word type.
- One sub-module, `if_id_reg`: 33-bit register {inst, pc_nx, valid} with load/hold/bubble select and async active-low reset. It is instantiated once.
- The FSM, skid buffer and pc_nx_q live in `fetch_stage`.

## Test plan
- Reset release, L=1 memory returning 16'h4123 then 16'h4124 at pc_addr 0/2:
  - imem_req at 0 then 2.
  - if_id_inst = 4123, then 4124, with if_id_pc_nx = 0002, then 0004.
  - pc_en pulses every 2nd cycle.
- stall=1 for 3 cycles while data 16'hA001 returns:
  - IF/ID holds its old value.
  - pc_en=0 for all 3 cycles.
  - When stall drops, IF/ID = A001 and pc_en pulses once.
- L=3, flush asserted in the 2nd WAIT cycle:
  - pc_en=1 that cycle and IF/ID becomes a bubble (0800, valid=0).
  - Returned data is discarded in DRAIN.
  - Next imem_req uses the new pc_addr.
- flush and stall together with imem_valid:
  - Bubble is loaded.
  - pc_en=1, and state FETCH next.
- Fetch 16'h0000 (HALT):
  - IF/ID valid, halted=1, no further imem_req for 10 cycles.
  - A subsequent flush restarts fetching.
- rst asserted in HOLD:
  - Outputs return to reset values immediately, without waiting for clk.
